// File: rtl/a2d_intf.sv
// SPI master for the ADC128S: each conversion is two 16-bit transfers of the channel command; the 2nd reply is the result.
// Latency strt_cnv->cnv_cmplt is 1045 clks (GAP_CLKS=2); strt_cnv is only accepted in IDLE, never queued.
module a2d_intf #(
   parameter int GAP_CLKS = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        strt_cnv,
   input  logic [2:0]  chnnl,
   output logic        cnv_cmplt,
   output logic [11:0] res,
   output logic        SS_n,
   output logic        SCLK,
   output logic        MOSI,
   input  logic        MISO
);

   localparam int              GW           = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;
   localparam logic [GW-1:0]   GAP_LAST     = GW'(GAP_CLKS - 1);
   localparam logic [4:0]      DIV_LOAD     = 5'b10111;
   localparam logic [4:0]      DIV_PRE_RISE = 5'b01111;
   localparam logic [4:0]      DIV_END      = 5'b11111;

   typedef enum logic [1:0] {IDLE, XFER1, GAP, XFER2} state_t;

   state_t         state_q, state_d;
   logic [4:0]     sclk_div_q, sclk_div_d;
   logic [4:0]     bit_cnt_q, bit_cnt_d;
   logic [15:0]    shft_reg_q, shft_reg_d;
   logic           ss_n_q, ss_n_d;
   logic [GW-1:0]  gap_cnt_q, gap_cnt_d;
   logic [2:0]     chnnl_q, chnnl_d;
   logic [11:0]    res_q, res_d;
   logic           cnv_cmplt_q, cnv_cmplt_d;
   logic           xfer_end;

   // 16 rises done and the divider sits where the 17th fall would be
   assign xfer_end = (sclk_div_q == DIV_END) && (bit_cnt_q == 5'd16);

   always_comb begin
      state_d     = state_q;
      sclk_div_d  = sclk_div_q;
      bit_cnt_d   = bit_cnt_q;
      shft_reg_d  = shft_reg_q;
      ss_n_d      = ss_n_q;
      gap_cnt_d   = gap_cnt_q;
      chnnl_d     = chnnl_q;
      res_d       = res_q;
      cnv_cmplt_d = cnv_cmplt_q;
      case (state_q)
         IDLE: begin
            if (strt_cnv) begin
               chnnl_d     = chnnl;
               cnv_cmplt_d = 1'b0;
               shft_reg_d  = {2'b00, chnnl, 11'h000};
               sclk_div_d  = DIV_LOAD;
               bit_cnt_d   = 5'd0;
               ss_n_d      = 1'b0;
               state_d     = XFER1;
            end
         end
         XFER1, XFER2: begin
            if (xfer_end) begin
               ss_n_d = 1'b1;
               if (state_q == XFER1) begin
                  gap_cnt_d = '0;
                  state_d   = GAP;
               end else begin
                  res_d       = shft_reg_q[11:0];
                  cnv_cmplt_d = 1'b1;
                  state_d     = IDLE;
               end
            end else begin
               sclk_div_d = sclk_div_q + 5'd1;
               if (sclk_div_q == DIV_PRE_RISE) begin
                  shft_reg_d = {shft_reg_q[14:0], MISO};
                  bit_cnt_d  = bit_cnt_q + 5'd1;
               end
            end
         end
         GAP: begin
            if (gap_cnt_q == GAP_LAST) begin
               shft_reg_d = {2'b00, chnnl_q, 11'h000};
               sclk_div_d = DIV_LOAD;
               bit_cnt_d  = 5'd0;
               ss_n_d     = 1'b0;
               state_d    = XFER2;
            end else begin
               gap_cnt_d = gap_cnt_q + GW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         sclk_div_q  <= DIV_END;
         bit_cnt_q   <= 5'd0;
         shft_reg_q  <= 16'h0000;
         ss_n_q      <= 1'b1;
         gap_cnt_q   <= '0;
         chnnl_q     <= 3'd0;
         res_q       <= 12'h000;
         cnv_cmplt_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         sclk_div_q  <= sclk_div_d;
         bit_cnt_q   <= bit_cnt_d;
         shft_reg_q  <= shft_reg_d;
         ss_n_q      <= ss_n_d;
         gap_cnt_q   <= gap_cnt_d;
         chnnl_q     <= chnnl_d;
         res_q       <= res_d;
         cnv_cmplt_q <= cnv_cmplt_d;
      end
   end

   // SCLK comes straight from a flop bit, so it cannot glitch on SS_n edges
   assign SCLK      = sclk_div_q[4];
   assign SS_n      = ss_n_q;
   assign MOSI      = shft_reg_q[15];
   assign res       = res_q;
   assign cnv_cmplt = cnv_cmplt_q;

endmodule

// File: tb/tb_a2d_intf.sv
// Bench for a2d_intf: ADC128S-style 2-cycle slave model, SPI waveform monitor, table and random conversions.
module tb_a2d_intf;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        strt_cnv;
   logic [2:0]  chnnl;
   logic        cnv_cmplt;
   logic [11:0] res;
   logic        SS_n;
   logic        SCLK;
   logic        MOSI;
   logic        MISO;

   a2d_intf #(.GAP_CLKS(2)) dut (
      .clk(clk), .rst_n(rst_n), .strt_cnv(strt_cnv), .chnnl(chnnl),
      .cnv_cmplt(cnv_cmplt), .res(res), .SS_n(SS_n), .SCLK(SCLK),
      .MOSI(MOSI), .MISO(MISO)
   );

   initial forever #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   // ADC model state: conversion data per channel, channel commanded in the previous frame
   logic [11:0] adc_data [8];
   logic [2:0]  adc_prev_ch = 3'd0;
   logic [15:0] tx;

   typedef struct {
      int          fall_at;
      int          rise_at;
      int          first_fall;
      int          nfall;
      int          nrise;
      bit          per_ok;
      int          rise_to_ss;
      logic [15:0] cmd;
   } txrec_t;
   txrec_t txq[$];

   int          mcyc = 0;
   int          idle_toggle = 0;
   logic        prev_ss = 1'b1;
   logic        prev_sclk = 1'b1;
   int          fall_at, first_fall, nfall, nrise, last_fall, last_rise;
   bit          per_ok;
   logic [15:0] cmd_rx;

   // Waveform monitor + ADC slave, sampled on the falling clock edge
   initial begin
      MISO = 1'b0;
      forever begin
         @(negedge clk);
         mcyc++;
         if (prev_ss && !SS_n) begin
            fall_at = mcyc; nfall = 0; nrise = 0; per_ok = 1'b1;
            cmd_rx = 16'h0; first_fall = -1; last_rise = mcyc;
            tx = {4'h0, adc_data[adc_prev_ch]};
         end
         if (!SS_n) begin
            if (prev_sclk && !SCLK) begin
               if (nfall == 0) first_fall = mcyc - fall_at;
               else if (mcyc - last_fall != 32) per_ok = 1'b0;
               last_fall = mcyc;
               cmd_rx = {cmd_rx[14:0], MOSI};
               if (nfall < 16) MISO = tx[15 - nfall];
               nfall++;
            end
            if (!prev_sclk && SCLK) begin
               nrise++;
               last_rise = mcyc;
            end
         end else if (prev_ss && (SCLK !== prev_sclk)) begin
            idle_toggle++;
         end
         if (!prev_ss && SS_n) begin
            txq.push_back('{fall_at, mcyc, first_fall, nfall, nrise, per_ok,
                            mcyc - last_rise, cmd_rx});
            adc_prev_ch = cmd_rx[13:11];
         end
         prev_ss = SS_n;
         prev_sclk = SCLK;
      end
   end

   logic [11:0] last_res_exp = 12'h000;

   // Caller is positioned just after a falling edge; strt_cnv is accepted at the next rising edge.
   task automatic run_conv(input string nm, input logic [2:0] ch, input bit spur,
                           input logic [2:0] spur_ch, input int hold,
                           input logic [11:0] exp_res, input logic [15:0] exp_cmd);
      int n = 0;
      bit seen = 1'b0;
      txrec_t r0, r1;
      strt_cnv = 1'b1;
      chnnl = ch;
      while (n < 1200 && !seen) begin
         @(negedge clk);
         n++;
         if (n == 1) begin
            strt_cnv = 1'b0;
            chk({nm, " cmplt_clr"}, cnv_cmplt, 1'b0);
            chk({nm, " res_hold"}, res, last_res_exp);
            chk({nm, " ss_low"}, SS_n, 1'b0);
         end
         chnnl = 3'($urandom);
         if (spur && n == 300) begin strt_cnv = 1'b1; chnnl = spur_ch; end
         if (spur && n == 301) strt_cnv = 1'b0;
         if (cnv_cmplt) seen = 1'b1;
      end
      chk({nm, " done"}, seen, 1'b1);
      chk({nm, " latency"}, n, 1045);
      chk({nm, " res"}, res, exp_res);
      last_res_exp = exp_res;
      #1;
      chk({nm, " frames"}, txq.size(), 2);
      if (txq.size() >= 2) begin
         r0 = txq.pop_front();
         r1 = txq.pop_front();
         chk({nm, " gap"}, r1.fall_at - r0.rise_at, 2);
         for (int k = 0; k < 2; k++) begin
            txrec_t r;
            r = (k == 0) ? r0 : r1;
            chk($sformatf("%s t%0d ss_low_time", nm, k), r.rise_at - r.fall_at, 521);
            chk($sformatf("%s t%0d first_fall", nm, k), r.first_fall, 9);
            chk($sformatf("%s t%0d falls", nm, k), r.nfall, 16);
            chk($sformatf("%s t%0d rises", nm, k), r.nrise, 16);
            chk($sformatf("%s t%0d period", nm, k), r.per_ok, 1'b1);
            chk($sformatf("%s t%0d rise_to_ss", nm, k), r.rise_to_ss, 16);
            chk($sformatf("%s t%0d cmd", nm, k), r.cmd, exp_cmd);
         end
      end
      txq.delete();
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk({nm, " cmplt_hold"}, cnv_cmplt, 1'b1);
         chk({nm, " res_keep"}, res, exp_res);
      end
   endtask

   typedef struct {
      logic [2:0]  ch;
      logic [11:0] data;
      bit          spur;
      logic [2:0]  spur_ch;
      int          hold;
      logic [11:0] exp_res;
      logic [15:0] exp_cmd;
   } vec_t;
   vec_t tbl[7];

   initial begin
      tbl[0] = '{3'd3, 12'hA5C, 1'b0, 3'd0, 3, 12'hA5C, 16'h1800};
      tbl[1] = '{3'd5, 12'h3C6, 1'b0, 3'd0, 0, 12'h3C6, 16'h2800};
      tbl[2] = '{3'd0, 12'hFFF, 1'b1, 3'd7, 0, 12'hFFF, 16'h0000};
      tbl[3] = '{3'd7, 12'h000, 1'b0, 3'd0, 2, 12'h000, 16'h3800};
      tbl[4] = '{3'd3, 12'h5A1, 1'b1, 3'd7, 1, 12'h5A1, 16'h1800};
      tbl[5] = '{3'd6, 12'h801, 1'b0, 3'd0, 0, 12'h801, 16'h3000};
      tbl[6] = '{3'd1, 12'h7FE, 1'b1, 3'd7, 2, 12'h7FE, 16'h0800};
      for (int i = 0; i < 8; i++) adc_data[i] = 12'($urandom);

      rst_n = 1'b0; strt_cnv = 1'b0; chnnl = 3'd0;
      repeat (3) @(negedge clk);
      chk("rst SS_n", SS_n, 1'b1);
      chk("rst SCLK", SCLK, 1'b1);
      chk("rst MOSI", MOSI, 1'b0);
      chk("rst cnv_cmplt", cnv_cmplt, 1'b0);
      chk("rst res", res, 12'h000);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      chk("idle SS_n", SS_n, 1'b1);
      txq.delete();

      for (int i = 0; i < 7; i++) begin
         adc_data[tbl[i].ch] = tbl[i].data;
         if (tbl[i].ch != 3'd7) adc_data[7] = ~tbl[i].data;
         run_conv($sformatf("vec%0d", i), tbl[i].ch, tbl[i].spur, tbl[i].spur_ch,
                  tbl[i].hold, tbl[i].exp_res, tbl[i].exp_cmd);
      end

      // Reset while the 8th bit of the first frame is on the wire
      strt_cnv = 1'b1; chnnl = 3'd2;
      @(negedge clk);
      strt_cnv = 1'b0;
      repeat (233) @(negedge clk);
      chk("mid SS_n before reset", SS_n, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("mid rst SS_n", SS_n, 1'b1);
      chk("mid rst SCLK", SCLK, 1'b1);
      chk("mid rst cnv_cmplt", cnv_cmplt, 1'b0);
      chk("mid rst res", res, 12'h000);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      chk("post rst SS_n", SS_n, 1'b1);
      chk("post rst SCLK", SCLK, 1'b1);
      txq.delete();
      last_res_exp = 12'h000;

      for (int i = 0; i < 8; i++) begin
         logic [2:0] ch;
         bit sp;
         for (int c = 0; c < 8; c++) adc_data[c] = 12'($urandom);
         ch = 3'($urandom_range(0, 7));
         sp = 1'($urandom);
         run_conv($sformatf("rnd%0d", i), ch, sp, 3'(~ch), $urandom_range(0, 3),
                  adc_data[ch], {2'b00, ch, 11'h000});
      end

      chk("sclk idle toggles", idle_toggle, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
